// File: rtl/cnn_accel_pkg.sv
// Shared constants, FSM state encoding and address-width helper for the
// cnn_accel classifier accelerator.
package cnn_accel_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int HEIGHT_DEF = 28;
  localparam int WIDTH_DEF  = 28;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A one-entry dimension still needs a 1-bit counter.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_accel_if.sv
// Operand bus from the memory read stage to the MAC bank.
// Handshake: valid marks pixel/coeff as one operand set for exactly the cycle
// it is high; there is no ready, the slave consumes every valid beat.
interface cnn_accel_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  logic                         valid;
  logic [DATA_W-1:0]            pixel;
  logic [DEPTH-1:0][DATA_W-1:0] coeff;

  modport master (output valid, pixel, coeff);
  modport slave  (input  valid, pixel, coeff);
endinterface

// File: rtl/cnn_accum.sv
// Bank of DEPTH multiply-accumulate lanes; products and sums wrap at DATA_W.
// Lane k lives in data_out[k*DATA_W +: DATA_W].
module cnn_accum
  import cnn_accel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic           clk,
  input logic           reset_n,
  cnn_accel_if.slave    mac
);

  logic [DEPTH*DATA_W-1:0] data_out;
  logic signed [DATA_W-1:0] prod [DEPTH];

  // Low DATA_W bits of a signed product equal the truncated result we want.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      prod[k] = $signed(mac.pixel) * $signed(mac.coeff[k]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (mac.valid) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_out[k*DATA_W +: DATA_W] <= data_out[k*DATA_W +: DATA_W] + prod[k];
      end
    end
  end

endmodule

// File: rtl/cnn_ram.sv
// Read-only HEIGHT x WIDTH word memory with a registered read port.
// Contents are loaded externally through the ram array and never reset.
module cnn_ram
  import cnn_accel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int WIDTH  = WIDTH_DEF
) (
  input  logic                      clk,
  input  logic [addr_w(HEIGHT)-1:0] row,
  input  logic [addr_w(WIDTH)-1:0]  col,
  output logic [DATA_W-1:0]         rd_data
);

  logic [DATA_W-1:0] ram [HEIGHT][WIDTH];

  always_ff @(posedge clk) begin
    rd_data <= ram[row][col];
  end

endmodule

// File: rtl/cnn_accel.sv
// Fully-connected classifier: streams the image and all coefficient memories
// in raster order through a MAC bank, then holds done until reset.
module cnn_accel
  import cnn_accel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic clk,
  input  logic reset_n,
  output logic done
);

  localparam int ROW_W = addr_w(HEIGHT);
  localparam int COL_W = addr_w(WIDTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  state_t            state, state_next;
  logic [ROW_W-1:0]  row, row_next;
  logic [COL_W-1:0]  col, col_next;
  logic              at_last;
  logic              rd_valid;
  logic [DATA_W-1:0] pixel;
  logic [DATA_W-1:0] coeff_data [DEPTH];

  cnn_accel_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) mac_bus ();

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_next;
      row      <= row_next;
      col      <= col_next;
      rd_valid <= (state == RUN);
    end
  end

  // RUN presents one address per cycle; DRAIN covers the final MAC beat.
  always_comb begin
    state_next = state;
    row_next   = row;
    col_next   = col;
    at_last    = (row == LAST_ROW) && (col == LAST_COL);
    case (state)
      IDLE:  state_next = RUN;
      RUN: begin
        if (at_last) begin
          state_next = DRAIN;
        end else if (col == LAST_COL) begin
          col_next = '0;
          row_next = row + 1'b1;
        end else begin
          col_next = col + 1'b1;
        end
      end
      DRAIN: state_next = DONE;
      DONE:  state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign done = (state == DONE);

  cnn_ram #(.DATA_W(DATA_W), .HEIGHT(HEIGHT), .WIDTH(WIDTH)) mem (
    .clk     (clk),
    .row     (row),
    .col     (col),
    .rd_data (pixel)
  );

  for (genvar k = 0; k < DEPTH; k++) begin : coeff
    cnn_ram #(.DATA_W(DATA_W), .HEIGHT(HEIGHT), .WIDTH(WIDTH)) mem (
      .clk     (clk),
      .row     (row),
      .col     (col),
      .rd_data (coeff_data[k])
    );
    assign mac_bus.coeff[k] = coeff_data[k];
  end

  assign mac_bus.valid = rd_valid;
  assign mac_bus.pixel = pixel;

  cnn_accum #(.DATA_W(DATA_W), .DEPTH(DEPTH)) comp (
    .clk     (clk),
    .reset_n (reset_n),
    .mac     (mac_bus.slave)
  );

endmodule

// File: tb/tb_cnn_accel.sv
// Directed bench for cnn_accel: backdoor-loads the memories during reset,
// checks per-class results, done latency/stickiness and mid-run reset.
module tb_cnn_accel;

  localparam int DATA_W = 32;
  localparam int HEIGHT = 28;
  localparam int WIDTH  = 28;
  localparam int DEPTH  = 4;
  localparam int DONE_LAT = HEIGHT * WIDTH + 2;
  localparam int BUDGET   = 2000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic done;
  int   checks = 0;
  int   errors = 0;

  cnn_accel #(.DATA_W(DATA_W), .HEIGHT(HEIGHT), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_coef(input int k, input int r, input int c, input logic [DATA_W-1:0] v);
    case (k)
      0: dut.coeff[0].mem.ram[r][c] = v;
      1: dut.coeff[1].mem.ram[r][c] = v;
      2: dut.coeff[2].mem.ram[r][c] = v;
      default: dut.coeff[3].mem.ram[r][c] = v;
    endcase
  endtask

  task automatic fill(input logic [DATA_W-1:0] img, input logic [DATA_W-1:0] cf [DEPTH]);
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        dut.mem.ram[r][c] = img;
        for (int k = 0; k < DEPTH; k++) set_coef(k, r, c, cf[k]);
      end
    end
  endtask

  task automatic check_results(input string tag, input logic [DATA_W-1:0] exp [DEPTH]);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("%s_class%0d", tag, k), dut.comp.data_out[k*DATA_W +: DATA_W], exp[k]);
    end
  endtask

  task automatic enter_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check({tag, "_rst_done"}, {31'd0, done}, 32'd0);
    check_results({tag, "_rst"}, '{32'd0, 32'd0, 32'd0, 32'd0});
  endtask

  // Release at a falling edge, then count rising edges until done is seen.
  task automatic release_and_wait(input string tag);
    int cyc;
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_done_latency"}, 32'(cyc), 32'(DONE_LAT));
  endtask

  task automatic run_case(input string tag, input logic [DATA_W-1:0] exp [DEPTH]);
    release_and_wait(tag);
    check_results(tag, exp);
  endtask

  initial begin
    logic [DATA_W-1:0] zeros [DEPTH];
    logic [DATA_W-1:0] ramp [DEPTH];
    logic [DATA_W-1:0] snap;
    zeros = '{32'd0, 32'd0, 32'd0, 32'd0};
    ramp  = '{32'd1, 32'd2, 32'd3, 32'd4};

    // All ones against coeff k+1, then done must stay high with stable results.
    enter_reset("ones");
    fill(32'd1, ramp);
    run_case("ones", '{32'd784, 32'd1568, 32'd2352, 32'd3136});
    snap = dut.comp.data_out[3*DATA_W +: DATA_W];
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      check("ones_done_sticky", {31'd0, done}, 32'd1);
    end
    check_results("ones_stable", '{32'd784, 32'd1568, 32'd2352, 32'd3136});

    // Zero image with random coefficients.
    enter_reset("zero_img");
    fill(32'd0, zeros);
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        for (int k = 0; k < DEPTH; k++) set_coef(k, r, c, $urandom);
    run_case("zero_img", zeros);

    // Single nonzero element: middle, first and last address.
    enter_reset("single_mid");
    fill(32'd0, zeros);
    dut.mem.ram[3][5] = 32'd7;
    set_coef(2, 3, 5, 32'd11);
    run_case("single_mid", '{32'd0, 32'd0, 32'd77, 32'd0});

    enter_reset("single_first");
    fill(32'd0, zeros);
    dut.mem.ram[0][0] = 32'd7;
    set_coef(2, 0, 0, 32'd11);
    run_case("single_first", '{32'd0, 32'd0, 32'd77, 32'd0});

    enter_reset("single_last");
    fill(32'd0, zeros);
    dut.mem.ram[27][27] = 32'd7;
    set_coef(2, 27, 27, 32'd11);
    run_case("single_last", '{32'd0, 32'd0, 32'd77, 32'd0});

    // 65536*65536 truncates to 0; coeff 1 lane gives 784*65536.
    enter_reset("trunc");
    fill(32'd65536, '{32'd65536, 32'd1, 32'd0, 32'd0});
    run_case("trunc", '{32'd0, 32'd51380224, 32'd0, 32'd0});

    // Signed operands: -2 * 3 * 784 = -4704.
    enter_reset("signed");
    fill(32'hFFFF_FFFE, '{32'd0, 32'd3, 32'd0, 32'd0});
    run_case("signed", '{32'd0, 32'hFFFF_EDA0, 32'd0, 32'd0});

    // Reset 100 cycles into a run must abort it and restart cleanly.
    enter_reset("abort");
    fill(32'd1, ramp);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("abort_mid_done", {31'd0, done}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort_async_done", {31'd0, done}, 32'd0);
    check_results("abort_async", zeros);
    repeat (2) @(negedge clk);
    run_case("abort_rerun", '{32'd784, 32'd1568, 32'd2352, 32'd3136});
    check("abort_vs_first", dut.comp.data_out[3*DATA_W +: DATA_W], snap);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
